ipsxe_floating_point_round_pipe_v1_0: RTL and testbench

Pipelined, parametrised rounding/saturation stage for float-to-fixed conversion. Input is a sign plus an already-aligned unsigned magnitude: integer field and fraction field, hidden one included. Output is a signed two's-complement integer.
- Rounding mode is selectable.
- Provides inexact and overflow flags and a valid/ready handshake with backpressure.
- Sits after the alignment shifter, before the fixed-point output register of the fl2fx path.

---
 rtl/ipsxe_floating_point_round_pipe_v1_0.sv | 184 ++++++++++++++++++
 tb/tb_ipsxe_floating_point_round_pipe_v1_0.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxe_floating_point_round_pipe_v1_0.sv
// -----------------------------------------------------------------------------
// ipsxe_floating_point_round_pipe_v1_0
//
// Rounding / saturation stage of the float-to-fixed path. Takes a sign plus an
// already-aligned unsigned magnitude (integer part with hidden one, and the
// fraction bits below it). It rounds the value according to the selected mode
// and saturates it into a signed two's-complement integer of INT_BIT bits.
// There are two register stages (S1, S2) with a valid/ready handshake and a
// global clock enable.
//
// Optional feature macro: IPSXE_FLT_ROUND_MODE_EN
//   defined   : i_rnd_mode selects RNE/RTZ/RUP/RDN/RNA (5-7 behave as RNE)
//   undefined : rounding is fixed to RNE and i_rnd_mode is ignored
//
// Parameters
//   INT_BIT   width of i_int and of the signed result o_data (>= 2)
//   FRAC_BIT  width of i_frac (>= 2)
//
// Ports
//   i_aclk      clock
//   i_rst       synchronous reset, active-high (clears the pipeline)
//   i_aclken    clock enable; low freezes every register and transfer
//   i_valid     input beat valid
//   o_ready     a beat can be accepted this cycle
//   i_sign      sign of the value (1 = negative)
//   i_int       unsigned integer magnitude
//   i_frac      fraction bits below the LSB of i_int
//   i_rnd_mode  0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4 RNA
//   o_valid     output beat valid
//   i_ready     downstream accepts the output beat
//   o_data      rounded, saturated signed result
//   o_inexact   fraction was nonzero or the result saturated
//   o_overflow  result saturated
// -----------------------------------------------------------------------------
module ipsxe_floating_point_round_pipe_v1_0 #(
    parameter int INT_BIT  = 32,
    parameter int FRAC_BIT = 24
) (
    input  logic                i_aclk,
    input  logic                i_rst,
    input  logic                i_aclken,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_sign,
    input  logic [INT_BIT-1:0]  i_int,
    input  logic [FRAC_BIT-1:0] i_frac,
    input  logic [2:0]          i_rnd_mode,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [INT_BIT-1:0]  o_data,
    output logic                o_inexact,
    output logic                o_overflow
);

    localparam logic [2:0] MODE_RNE = 3'd0;
    localparam logic [2:0] MODE_RTZ = 3'd1;
    localparam logic [2:0] MODE_RUP = 3'd2;
    localparam logic [2:0] MODE_RDN = 3'd3;
    localparam logic [2:0] MODE_RNA = 3'd4;

    // Fraction pattern of exactly one half: 100...0
    localparam logic [FRAC_BIT-1:0] FRAC_HALF = {1'b1, {(FRAC_BIT-1){1'b0}}};

    // Largest magnitudes representable for a positive / negative result,
    // expressed at INT_BIT+1 bits so the carry of the increment is kept.
    localparam logic [INT_BIT:0] POS_LIMIT = {2'b00, {(INT_BIT-1){1'b1}}};
    localparam logic [INT_BIT:0] NEG_LIMIT = {2'b01, {(INT_BIT-1){1'b0}}};

    localparam logic [INT_BIT-1:0] SAT_POS = {1'b0, {(INT_BIT-1){1'b1}}};
    localparam logic [INT_BIT-1:0] SAT_NEG = {1'b1, {(INT_BIT-1){1'b0}}};

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic s1_valid;
    logic s2_open;   // S2 is empty or its beat leaves this cycle
    logic s1_open;   // S1 is empty or its beat moves into S2 this cycle

    assign s2_open = !o_valid || i_ready;
    assign s1_open = !s1_valid || s2_open;
    // Combinational from downstream ready so a full pipeline streams without
    // a bubble.
    assign o_ready = i_aclken && !i_rst && s1_open;

    // -------------------------------------------------------------------------
    // S1: capture operands and pre-classify the fraction
    // -------------------------------------------------------------------------
    logic                s1_sign;
    logic [INT_BIT-1:0]  s1_int;
    logic                s1_half;
    logic                s1_above;
    logic                s1_nz;
    logic [2:0]          mode_eff;

    always_ff @(posedge i_aclk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples values from before the edge, whatever the order of blocks.
        if (i_rst) begin
            s1_valid <= 1'b0;
        end else if (i_aclken && s1_open) begin
            s1_valid <= i_valid;
        end
    end

    // NOTE: the payload flops are intentionally not reset; the valid bits
    // qualify them, and leaving them out of reset keeps the reset fan-out small.
    always_ff @(posedge i_aclk) begin
        if (i_aclken && s1_open && i_valid) begin
            s1_sign  <= i_sign;
            s1_int   <= i_int;
            s1_half  <= (i_frac == FRAC_HALF);
            s1_above <= (i_frac > FRAC_HALF);
            s1_nz    <= |i_frac;
        end
    end

`ifdef IPSXE_FLT_ROUND_MODE_EN
    logic [2:0] s1_mode;

    always_ff @(posedge i_aclk) begin
        if (i_aclken && s1_open && i_valid) begin
            s1_mode <= i_rnd_mode;
        end
    end

    assign mode_eff = s1_mode;
`else
    // The port is kept so both builds share one interface.
    logic unused_rnd_mode;
    assign unused_rnd_mode = ^i_rnd_mode;
    assign mode_eff        = MODE_RNE;
`endif

    // -------------------------------------------------------------------------
    // S2 datapath: round, then saturate
    // -------------------------------------------------------------------------
    logic               inc;
    logic [INT_BIT:0]   mag;
    logic               ovf;
    logic [INT_BIT-1:0] mag_lo;
    logic [INT_BIT-1:0] result;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        inc = 1'b0;
        case (mode_eff)
            MODE_RTZ: inc = 1'b0;
            MODE_RUP: inc = s1_nz && !s1_sign;
            MODE_RDN: inc = s1_nz && s1_sign;
            MODE_RNA: inc = s1_above || s1_half;
            // RNE, and the reserved codes 5-7
            default:  inc = s1_above || (s1_half && s1_int[0]);
        endcase
    end

    // One extra bit keeps the carry out of the increment (no wrap).
    assign mag    = {1'b0, s1_int} + {{INT_BIT{1'b0}}, inc};
    assign ovf    = s1_sign ? (mag > NEG_LIMIT) : (mag > POS_LIMIT);
    assign mag_lo = mag[INT_BIT-1:0];

    // For the negative side a magnitude of exactly 2^(INT_BIT-1) is legal and
    // its low bits negate to 100..0. Negating zero gives zero.
    assign result = ovf     ? (s1_sign ? SAT_NEG : SAT_POS)
                  : s1_sign ? ({INT_BIT{1'b0}} - mag_lo)
                  :           mag_lo;

    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_inexact  <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_aclken && s2_open) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data     <= result;
                o_inexact  <= s1_nz || ovf;
                o_overflow <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_round_pipe_v1_0.sv
// -----------------------------------------------------------------------------
// tb_ipsxe_floating_point_round_pipe_v1_0
//
// Self-checking bench for the round/saturate pipe at INT_BIT=8, FRAC_BIT=4.
// Accepted input beats are evaluated by an arithmetic reference model and
// queued. A single negedge monitor compares every output transfer against that
// queue and checks that the outputs hold while stalled or disabled. Directed
// beats also pin the model against hand-computed results.
// -----------------------------------------------------------------------------
module tb_ipsxe_floating_point_round_pipe_v1_0;

    localparam int IW = 8;
    localparam int FW = 4;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RUP = 3'd2;
    localparam logic [2:0] RDN = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    logic          i_aclk     = 1'b0;
    logic          i_rst      = 1'b1;
    logic          i_aclken   = 1'b1;
    logic          i_valid    = 1'b0;
    logic          i_sign     = 1'b0;
    logic [IW-1:0] i_int      = '0;
    logic [FW-1:0] i_frac     = '0;
    logic [2:0]    i_rnd_mode = 3'd0;
    logic          i_ready    = 1'b1;
    logic          o_ready;
    logic          o_valid;
    logic [IW-1:0] o_data;
    logic          o_inexact;
    logic          o_overflow;

    ipsxe_floating_point_round_pipe_v1_0 #(
        .INT_BIT  (IW),
        .FRAC_BIT (FW)
    ) dut (
        .i_aclk     (i_aclk),
        .i_rst      (i_rst),
        .i_aclken   (i_aclken),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_sign     (i_sign),
        .i_int      (i_int),
        .i_frac     (i_frac),
        .i_rnd_mode (i_rnd_mode),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_inexact  (o_inexact),
        .o_overflow (o_overflow)
    );

    always #5 i_aclk = ~i_aclk;

    typedef struct packed {
        logic [IW-1:0] data;
        logic          inx;
        logic          ovf;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    bit   lat_chk  = 0;
    bit   saw_bp   = 0;
    bit   rnd_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: value = mag + frac/16, rounded by mode and clamped to the
    // signed 8-bit range [-128, 127].
    function automatic res_t model(input logic s, input logic [IW-1:0] mag,
                                   input logic [FW-1:0] fr, input logic [2:0] md);
        int   mode;
        int   m;
        int   v;
        int   f;
        bit   up;
        bit   ovf;
        res_t r;
        mode = int'(md);
`ifndef IPSXE_FLT_ROUND_MODE_EN
        mode = 0;
`endif
        if (mode > 4) mode = 0;
        f = int'(fr);                 // fraction in sixteenths; 8 is one half
        case (mode)
            1:       up = 1'b0;
            2:       up = (f != 0) && !s;
            3:       up = (f != 0) && s;
            4:       up = (f >= 8);
            default: up = (f > 8) || (f == 8 && (int'(mag) % 2) == 1);
        endcase
        m   = int'(mag) + int'(up);
        ovf = s ? (m > 128) : (m > 127);
        v   = ovf ? (s ? -128 : 127) : (s ? -m : m);
        r.data = v[IW-1:0];
        r.inx  = (f != 0) || ovf;
        r.ovf  = ovf;
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge
    // ---------------------------------------------------------------------
    always @(posedge i_aclk) cyc++;

    logic [IW-1:0] prev_data;
    logic          prev_valid, prev_inx, prev_ovf;
    bit            frz = 0;

    always @(negedge i_aclk) begin
        if (i_rst) begin
            check("ready_in_reset", {31'd0, o_ready}, 32'd0);
            q.delete();
            frz = 0;
        end else begin
            if (frz)
                check("hold_outputs", {o_valid, o_data, o_inexact, o_overflow},
                      {prev_valid, prev_data, prev_inx, prev_ovf});
            if (!i_aclken)
                check("ready_when_disabled", {31'd0, o_ready}, 32'd0);
            if (i_aclken && i_valid && !o_ready)
                saw_bp = 1;
            if (i_valid && o_ready) begin
                e_mon.r   = model(i_sign, i_int, i_frac, i_rnd_mode);
                e_mon.cyc = cyc;
                q.push_back(e_mon);
            end
            if (o_valid && i_ready && i_aclken) begin
                if (q.size() == 0) begin
                    check("spurious_output", {31'd0, o_valid}, 32'd0);
                end else begin
                    e_mon = q.pop_front();
                    check("result", {22'd0, o_data, o_inexact, o_overflow}, {22'd0, e_mon.r});
                    if (lat_chk)
                        check("latency", cyc - e_mon.cyc, 32'd2);
                end
            end
            frz        = (o_valid && !i_ready) || !i_aclken;
            prev_valid = o_valid;
            prev_data  = o_data;
            prev_inx   = o_inexact;
            prev_ovf   = o_overflow;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ---------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(posedge i_aclk);
        #1;
    endtask

    task automatic send(input logic s, input logic [IW-1:0] mag,
                        input logic [FW-1:0] fr, input logic [2:0] md);
        bit done;
        done       = 0;
        i_valid    = 1'b1;
        i_sign     = s;
        i_int      = mag;
        i_frac     = fr;
        i_rnd_mode = md;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge i_aclk);
            if (o_ready) done = 1;
            @(posedge i_aclk);
            #1;
        end
        i_valid = 1'b0;
        if (!done) check("send_timeout", {31'd0, done}, 32'd1);
    endtask

    // Pins the model to a hand-computed result, then sends the beat so the
    // monitor checks the DUT against the model.
    task automatic send_lit(input string nm, input logic s, input logic [IW-1:0] mag,
                            input logic [FW-1:0] fr, input logic [2:0] md,
                            input logic [IW-1:0] d, input logic x, input logic o);
        res_t r;
        r = model(s, mag, fr, md);
        check(nm, {22'd0, r}, {22'd0, d, x, o});
        send(s, mag, fr, md);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge i_aclk);
        check("drain_empty", q.size(), 32'd0);
        idle(1);
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        // Reset state
        @(posedge i_aclk);
        #1;
        @(negedge i_aclk);
        check("reset_outputs", {28'd0, o_valid, o_inexact, o_overflow, o_ready}, 32'd0);
        check("reset_data", {24'd0, o_data}, 32'd0);
        @(posedge i_aclk);
        #1;
        i_rst = 1'b0;
        idle(1);

        // RNE ties and latency
        lat_chk = 1;
        send_lit("rne_tie_even", 1'b0, 8'd2, 4'b1000, RNE, 8'h02, 1'b1, 1'b0);
        send_lit("rne_tie_odd",  1'b0, 8'd3, 4'b1000, RNE, 8'h04, 1'b1, 1'b0);
        send_lit("rne_above",    1'b0, 8'd2, 4'b1001, RNE, 8'h03, 1'b1, 1'b0);
        drain();
        lat_chk = 0;

        // Saturation boundaries
        send_lit("sat_pos",      1'b0, 8'd127, 4'b1000, RNE, 8'h7F, 1'b1, 1'b1);
        send_lit("neg_min_exact", 1'b1, 8'd128, 4'b0000, RNE, 8'h80, 1'b0, 1'b0);
`ifdef IPSXE_FLT_ROUND_MODE_EN
        send_lit("sat_neg_rdn",  1'b1, 8'd128, 4'b0001, RDN, 8'h80, 1'b1, 1'b1);
        // Rounding modes
        send_lit("mode_rtz",     1'b1, 8'd5, 4'b0100, RTZ, 8'hFB, 1'b1, 1'b0);
        send_lit("mode_rdn",     1'b1, 8'd5, 4'b0100, RDN, 8'hFA, 1'b1, 1'b0);
        send_lit("mode_rup",     1'b1, 8'd5, 4'b0100, RUP, 8'hFB, 1'b1, 1'b0);
        send_lit("mode_rna",     1'b1, 8'd5, 4'b1000, RNA, 8'hFA, 1'b1, 1'b0);
        send_lit("neg_zero",     1'b1, 8'd0, 4'b0001, RUP, 8'h00, 1'b1, 1'b0);
`else
        send_lit("neg_min_rne",  1'b1, 8'd128, 4'b0001, RDN, 8'h80, 1'b1, 1'b0);
        send_lit("forced_rne",   1'b0, 8'd2, 4'b1000, RTZ, 8'h02, 1'b1, 1'b0);
        send_lit("forced_rne_n", 1'b1, 8'd5, 4'b0100, RDN, 8'hFB, 1'b1, 1'b0);
`endif
        send_lit("reserved_mode", 1'b0, 8'd3, 4'b1000, 3'd7, 8'h04, 1'b1, 1'b0);
        drain();

        // Backpressure: 6 back-to-back beats, 4-cycle stall after first output
        saw_bp = 0;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(1'(k % 2), 8'(40 + 3 * k), 4'(k * 3), RNE);
            end
            begin
                for (int k = 0; k < 50 && !o_valid; k++) @(negedge i_aclk);
                @(posedge i_aclk);
                #1;
                i_ready = 1'b0;
                idle(4);
                i_ready = 1'b1;
            end
        join
        drain();
        check("bp_ready_drop", {31'd0, saw_bp}, 32'd1);

        // Reset with two beats in flight
        send(1'b0, 8'd20, 4'd3, RNE);
        send(1'b0, 8'd21, 4'd3, RNE);
        i_rst = 1'b1;
        @(negedge i_aclk);
        check("midrst_ready_low", {31'd0, o_ready}, 32'd0);
        @(posedge i_aclk);
        #1;
        i_rst = 1'b0;
        @(negedge i_aclk);
        check("midrst_cleared", {28'd0, o_valid, o_inexact, o_overflow, 1'b0}, 32'd0);
        check("midrst_data", {24'd0, o_data}, 32'd0);
        check("midrst_ready_back", {31'd0, o_ready}, 32'd1);
        @(posedge i_aclk);
        #1;
        lat_chk = 1;
        send(1'b1, 8'd9, 4'd12, RNE);
        drain();
        lat_chk = 0;

        // Clock enable dropped for 3 cycles mid-stream
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(1'(k / 3), 8'(60 + k), 4'(k + 6), 3'($urandom_range(0, 4)));
            end
            begin
                idle(3);
                i_aclken = 1'b0;
                idle(3);
                i_aclken = 1'b1;
            end
        join
        drain();

        // Randomized stream with random backpressure and clock-enable gaps
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [IW-1:0] mag;
                    if ($urandom_range(0, 3) == 0) mag = 8'($urandom_range(125, 129) & 8'hFF);
                    else                           mag = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
                    send(1'($urandom_range(0, 1)), mag, 4'($urandom_range(0, 15)),
                         3'($urandom_range(0, 7)));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge i_aclk);
                    #1;
                    i_ready  = ($urandom_range(0, 3) != 0);
                    i_aclken = ($urandom_range(0, 9) != 0);
                end
                i_ready  = 1'b1;
                i_aclken = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
